// File: rtl/uart_port_arbiter.sv
// Round-robin arbiter that shares one SimUART model between the core (port 0)
// and the debug/DMA path (port 1), with one UART access in flight at a time.
module uart_port_arbiter #(
  parameter int XLEN = 64,
  parameter int AW   = 8,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_wen,
  input  logic [AW-1:0]   req0_addr,
  input  logic [DW-1:0]   req0_wdata,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [XLEN-1:0] resp0_rdata,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_wen,
  input  logic [AW-1:0]   req1_addr,
  input  logic [DW-1:0]   req1_wdata,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp1_rdata,
  output logic            uart_wen,
  output logic [AW-1:0]   uart_waddr,
  output logic [DW-1:0]   uart_wdata,
  output logic            uart_ren,
  output logic [AW-1:0]   uart_raddr,
  input  logic [XLEN-1:0] uart_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic            r_rrLast;
  logic            r_owner;
  logic            r_isWrite;
  logic [XLEN-1:0] r_rdata;
  logic            r_uartWen;
  logic            r_uartRen;
  logic [AW-1:0]   r_uartWaddr;
  logic [AW-1:0]   r_uartRaddr;
  logic [DW-1:0]   r_uartWdata;

  logic            w_grant0;
  logic            w_grant1;
  logic            w_accept;
  logic            w_respFire;
  logic            w_selWen;
  logic [AW-1:0]   w_selAddr;
  logic [DW-1:0]   w_selWdata;

  // rr_last only matters when both ports ask in the same cycle.
  always_comb begin
    w_stateNext = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_respFire  = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant0 = req0_valid && (!req1_valid || r_rrLast);
        w_grant1 = req1_valid && (!req0_valid || !r_rrLast);
        if (w_grant0 || w_grant1) w_stateNext = ISSUE;
      end
      ISSUE:   w_stateNext = r_isWrite ? RESP : CAPTURE;
      CAPTURE: w_stateNext = RESP;
      RESP: begin
        w_respFire = r_owner ? resp1_ready : resp0_ready;
        if (w_respFire) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign w_accept   = w_grant0 | w_grant1;
  assign w_selWen   = w_grant1 ? req1_wen   : req0_wen;
  assign w_selAddr  = w_grant1 ? req1_addr  : req0_addr;
  assign w_selWdata = w_grant1 ? req1_wdata : req0_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Strobes are loaded on the accept edge so they are live for exactly the ISSUE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rrLast    <= 1'b1;
      r_owner     <= 1'b0;
      r_isWrite   <= 1'b0;
      r_rdata     <= '0;
      r_uartWen   <= 1'b0;
      r_uartRen   <= 1'b0;
      r_uartWaddr <= '0;
      r_uartRaddr <= '0;
      r_uartWdata <= '0;
    end else begin
      if (w_accept) begin
        r_owner     <= w_grant1;
        r_isWrite   <= w_selWen;
        r_uartWen   <= w_selWen;
        r_uartRen   <= !w_selWen;
        r_uartWaddr <= w_selWen ? w_selAddr  : '0;
        r_uartWdata <= w_selWen ? w_selWdata : '0;
        r_uartRaddr <= w_selWen ? '0 : w_selAddr;
      end
      if (r_state == ISSUE) begin
        r_uartWen   <= 1'b0;
        r_uartRen   <= 1'b0;
        r_uartWaddr <= '0;
        r_uartWdata <= '0;
        r_uartRaddr <= '0;
        if (r_isWrite) r_rdata <= '0;
      end
      if (r_state == CAPTURE) r_rdata <= uart_rdata;
      if (w_respFire) r_rrLast <= r_owner;
    end
  end

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign resp0_valid = (r_state == RESP) && !r_owner;
  assign resp1_valid = (r_state == RESP) && r_owner;
  assign resp0_rdata = resp0_valid ? r_rdata : '0;
  assign resp1_rdata = resp1_valid ? r_rdata : '0;
  assign uart_wen    = r_uartWen;
  assign uart_ren    = r_uartRen;
  assign uart_waddr  = r_uartWaddr;
  assign uart_wdata  = r_uartWdata;
  assign uart_raddr  = r_uartRaddr;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed bench for uart_port_arbiter: a SimUART register model plus a
// scoreboard of expected strobes and responses filled at each accept.
module tb_uart_port_arbiter;

  typedef struct {
    logic       wen;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         cyc;
  } strobe_t;

  typedef struct {
    int          port;
    logic [63:0] rdata;
    logic        wen;
    int          cyc;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req0_wen = 1'b0;
  logic [7:0]  req0_addr = '0, req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_wen = 1'b0;
  logic [7:0]  req1_addr = '0, req1_wdata = '0;
  logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [63:0] resp0_rdata, resp1_rdata;
  logic        uart_wen, uart_ren;
  logic [7:0]  uart_waddr, uart_wdata, uart_raddr;
  logic [63:0] uart_rdata = '0;

  logic [63:0] uartMem [256];
  logic [63:0] expMem [256];
  strobe_t     sbStrobe [$];
  resp_t       sbResp [$];
  resp_t       curResp;
  logic        respActive = 1'b0;
  logic        altMode = 1'b0;
  int          expNextPort = 0;
  int          cycleCnt = 0;
  int          lastStrobe = -100;
  int          nAssert = 0;
  int          nFail = 0;

  uart_port_arbiter #(.XLEN(64), .AW(8), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wen(req0_wen),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wen(req1_wen),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_rdata(resp1_rdata),
    .uart_wen(uart_wen), .uart_waddr(uart_waddr), .uart_wdata(uart_wdata),
    .uart_ren(uart_ren), .uart_raddr(uart_raddr), .uart_rdata(uart_rdata)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // SimUART stand-in: read data appears on the edge that ends the ren cycle.
  always @(posedge clk) begin
    if (uart_wen) uartMem[uart_waddr] <= {56'h0, uart_wdata};
    if (uart_ren) uart_rdata <= uartMem[uart_raddr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic flushScoreboard();
    sbStrobe.delete();
    sbResp.delete();
    respActive = 1'b0;
    lastStrobe = -100;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req0_ready"}, 64'(req0_ready), 64'h0);
    checkOutput({tag, "_req1_ready"}, 64'(req1_ready), 64'h0);
    checkOutput({tag, "_resp0_valid"}, 64'(resp0_valid), 64'h0);
    checkOutput({tag, "_resp1_valid"}, 64'(resp1_valid), 64'h0);
    checkOutput({tag, "_resp0_rdata"}, resp0_rdata, 64'h0);
    checkOutput({tag, "_resp1_rdata"}, resp1_rdata, 64'h0);
    checkOutput({tag, "_uart_strobes"}, 64'({uart_wen, uart_ren}), 64'h0);
    checkOutput({tag, "_uart_bus"}, 64'({uart_waddr, uart_wdata, uart_raddr}), 64'h0);
  endtask

  // Raises a request, holds it until accepted, and books the expected strobe and response.
  task automatic applyStimulus(input int port, input logic wen, input logic [7:0] addr,
                               input logic [7:0] wdata);
    logic got;
    int   waitCnt;
    logic [63:0] expData;
    if (port == 0) begin
      req0_wen = wen; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1;
    end else begin
      req1_wen = wen; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1;
    end
    got = 1'b0;
    waitCnt = 0;
    while (!got && waitCnt < 200) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) got = 1'b1;
      else waitCnt++;
    end
    checkOutput($sformatf("accept_p%0d", port), 64'(got), 64'h1);
    if (got) begin
      if (altMode) begin
        checkOutput("grantOrder", 64'(port), 64'(expNextPort));
        expNextPort = 1 - port;
      end
      expData = wen ? 64'h0 : expMem[addr];
      if (wen) expMem[addr] = {56'h0, wdata};
      sbStrobe.push_back('{wen: wen, addr: addr, wdata: wdata, cyc: cycleCnt});
      sbResp.push_back('{port: port, rdata: expData, wen: wen, cyc: cycleCnt});
      @(posedge clk);
      #1;
    end
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int k;
    k = 0;
    while ((sbStrobe.size() != 0 || sbResp.size() != 0 || respActive) && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_drain"}, 64'(k < 100), 64'h1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: strobe shape/latency/spacing and response contents/stability.
  always @(negedge clk) begin
    strobe_t s;
    if (!reset) begin
      if (uart_wen || uart_ren) begin
        checkOutput("strobeExclusive", 64'(uart_wen & uart_ren), 64'h0);
        checkOutput("strobeExpected", 64'(sbStrobe.size() != 0), 64'h1);
        if (sbStrobe.size() != 0) begin
          s = sbStrobe.pop_front();
          checkOutput("strobeWen", 64'(uart_wen), 64'(s.wen));
          checkOutput("strobeAddr", 64'(s.wen ? uart_waddr : uart_raddr), 64'(s.addr));
          checkOutput("strobeUnusedAddr", 64'(s.wen ? uart_raddr : uart_waddr), 64'h0);
          checkOutput("strobeData", 64'(uart_wdata), 64'(s.wen ? s.wdata : 8'h0));
          checkOutput("strobeLatency", 64'(cycleCnt - s.cyc), 64'd1);
          checkOutput("strobeSpacing", 64'((cycleCnt - lastStrobe) >= 3), 64'h1);
          lastStrobe = cycleCnt;
        end
      end
      checkOutput("respOneHot", 64'(resp0_valid & resp1_valid), 64'h0);
      if (resp0_valid || resp1_valid) begin
        checkOutput("readyInResp", 64'({req0_ready, req1_ready}), 64'h0);
        if (!respActive) begin
          checkOutput("respExpected", 64'(sbResp.size() != 0), 64'h1);
          if (sbResp.size() != 0) begin
            curResp = sbResp.pop_front();
            respActive = 1'b1;
            checkOutput("respLatency", 64'(cycleCnt - curResp.cyc), curResp.wen ? 64'd2 : 64'd3);
          end
        end
        if (respActive) begin
          checkOutput("respPort", 64'(resp1_valid), 64'(curResp.port));
          checkOutput("respRdata", resp1_valid ? resp1_rdata : resp0_rdata, curResp.rdata);
          if (resp1_valid ? resp1_ready : resp0_ready) respActive = 1'b0;
        end
      end else begin
        checkOutput("respHeld", 64'(respActive), 64'h0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      uartMem[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 3);
      expMem[i]  = 64'hA5A5_0000_0000_0000 | 64'(i * 3);
    end
    uartMem[8'h05] = 64'h60;     expMem[8'h05] = 64'h60;
    uartMem[8'h10] = 64'h1234;   expMem[8'h10] = 64'h1234;

    #1;
    checkResetOutputs("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus(0, 1'b1, 8'h00, 8'h41);
    waitIdle("singleWrite");

    applyStimulus(1, 1'b0, 8'h05, 8'h00);
    waitIdle("singleRead");

    // Port 1 owned the last response, so port 0 wins the first tie.
    altMode = 1'b1;
    expNextPort = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 8'(8'h20 + i), 8'(8'hA0 + i));
      end
      begin
        for (int j = 0; j < 4; j++) applyStimulus(1, 1'b1, 8'(8'h30 + j), 8'(8'hB0 + j));
      end
    join
    altMode = 1'b0;
    waitIdle("contention");

    resp0_ready = 1'b0;
    fork
      applyStimulus(0, 1'b0, 8'h10, 8'h00);
      begin
        @(posedge clk);
        #1;
        applyStimulus(1, 1'b1, 8'h40, 8'h55);
      end
      begin
        int k;
        k = 0;
        while (!resp0_valid && k < 50) begin
          @(negedge clk);
          k++;
        end
        checkOutput("bpRespSeen", 64'(resp0_valid), 64'h1);
        repeat (10) @(negedge clk);
        checkOutput("bpStillValid", 64'(resp0_valid), 64'h1);
        @(posedge clk);
        #1 resp0_ready = 1'b1;
      end
    join
    waitIdle("backpressure");

    applyStimulus(0, 1'b0, 8'h07, 8'h00);
    @(posedge clk);
    #1 reset = 1'b1;
    flushScoreboard();
    #1;
    checkResetOutputs("resetCapture");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    applyStimulus(1, 1'b1, 8'h60, 8'h77);
    checkOutput("issueStrobeBeforeReset", 64'(uart_wen), 64'h1);
    reset = 1'b1;
    flushScoreboard();
    #1;
    checkResetOutputs("resetIssue");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    altMode = 1'b1;
    expNextPort = 0;
    fork
      applyStimulus(0, 1'b1, 8'h50, 8'h11);
      applyStimulus(1, 1'b1, 8'h51, 8'h22);
    join
    altMode = 1'b0;
    waitIdle("afterReset");

    applyStimulus(1, 1'b0, 8'h05, 8'h00);
    applyStimulus(1, 1'b0, 8'h10, 8'h00);
    applyStimulus(1, 1'b0, 8'h21, 8'h00);
    waitIdle("repeatOwner");

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/uart_port_arbiter.md
Name: uart_port_arbiter

Overview:
- Shares the single SimUART DPI model between two MMIO requesters: port 0 is the core, port 1 is the debug/DMA path.
- Arbitrates between the two requesters round-robin.
- Sequences each access into a one-cycle wen or ren strobe toward SimUART.
- Captures read data and returns a response to the owning requester over a valid/ready handshake.
- Sits between the MMIO crossbar and the SimUART instance. Exactly one UART access is in flight at any time.

Parameters:
- XLEN, 64, width of read data returned by SimUART and by the response ports
- AW, 8, UART register address width
- DW, 8, UART write data width

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- req0_valid  input  1  port 0 request valid
- req0_ready  output  1  port 0 request accepted this cycle
- req0_wen  input  1  1 = write, 0 = read
- req0_addr  input  AW  register address
- req0_wdata  input  DW  write data
- resp0_valid  output  1  port 0 response valid
- resp0_ready  input  1  port 0 response consumed
- resp0_rdata  output  XLEN  read data; 0 for writes
- req1_* / resp1_*  same widths and meanings, for port 1
- uart_wen  output  1  to SimUART wen
- uart_waddr  output  AW  to SimUART waddr
- uart_wdata  output  DW  to SimUART wdata
- uart_ren  output  1  to SimUART ren
- uart_raddr  output  AW  to SimUART raddr
- uart_rdata  input  XLEN  from SimUART rdata

Behaviour:
- Reset (asynchronous) forces all of the following, regardless of the current state:
  - state = IDLE, rr_last = 1 (so port 0 wins first)
  - req*_ready = 0, resp*_valid = 0, resp*_rdata = 0
  - uart_wen = uart_ren = 0; uart_waddr, uart_wdata, uart_raddr = 0
  - Any in-flight access is abandoned: no strobe is emitted after reset, and no response is delivered.
- State IDLE:
  - Grant goes to the single valid port.
  - If both ports are valid, grant goes to the port != rr_last.
  - reqN_ready = grant (combinational, IDLE only); at most one ready is high.
  - On the accept edge, latch wen/addr/wdata and owner = N, then go to ISSUE.
  - If no port is valid, stay in IDLE.
- State ISSUE (exactly 1 cycle):
  - Drive uart_wen = latched wen, or uart_ren = !latched wen, from registers; never both.
  - Drive waddr/raddr and wdata from the latch; unused address/data outputs are held at 0.
  - Write: go to RESP with rdata = 0.
  - Read: go to CAPTURE.
- State CAPTURE (1 cycle, read only):
  - SimUART updates rdata at the ISSUE edge, so uart_rdata is sampled at the end of CAPTURE into the response register.
  - Go to RESP.
- State RESP:
  - resp{owner}_valid = 1 with rdata stable; hold until resp{owner}_ready.
  - On the handshake edge: rr_last = owner, valid drops, go to IDLE.
  - The other port's response valid stays 0 throughout.
- Latency, accept edge to resp_valid high: 2 cycles for a write, 3 cycles for a read. Minimum issue spacing is 3 cycles (writes) and 4 cycles (reads).
- New requests:
  - Not accepted outside IDLE; ready stays low and the requester must hold its request stable.
  - A request raised during RESP is arbitrated on the cycle after the handshake.
- Back-to-back: if the same port is valid again and the other port is idle, it is granted again (rr_last only breaks ties).
- Strobe rules: uart_wen/uart_ren never assert outside ISSUE and never for more than 1 cycle per accepted request.
- Reset asserted mid-ISSUE: the strobe drops asynchronously with reset.

Test Plan:
- Single write: port 0 writes addr 0x00, data 0x41 → uart_wen high for exactly 1 cycle, 1 cycle after accept, with waddr 0x00 and wdata 0x41; resp0_valid 2 cycles after accept with rdata 0.
- Single read: port 1 reads addr 0x05; DPI model returns 0x60 → uart_ren for 1 cycle with raddr 0x05; resp1_rdata = 0x60, resp1_valid 3 cycles after accept; uart_wen stays 0.
- Contention: both ports valid continuously, 4 writes each → grants alternate 0,1,0,1…; port 0 goes first after reset; no two strobes within 3 cycles.
- Response backpressure: resp0_ready held low for 10 cycles during a read with rdata 0x1234 → resp0_valid and rdata stay stable; port 1 is not granted until the handshake; exactly one uart_ren observed.
- Reset mid-operation: assert reset during CAPTURE → all outputs 0 immediately, no response delivered; the next request after deassert is serviced normally with port 0 priority.
- Repeat owner: port 1 alone issues 3 reads → all 3 granted, responses returned in order, one ren each.
